sine_sdm_gen: RTL

- Parametrised successor of the board's fixed 16-step sine/first-order modulator test generator.
- Direct digital synthesis (DDS) sine source with a programmable frequency tuning word (FTW) and amplitude.
- Feeds a selectable first- or second-order delta-sigma modulator producing a 1-bit drive output.
- Drives the excitation pin of the sensor readout front end; provides a scope trigger and a multibit sample tap for debug.

---
 rtl/sdm_pkg.sv | 49 ++++
 rtl/sine_rom.sv | 37 +++
 rtl/sine_sdm_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sdm_pkg.sv
// sdm_pkg: shared types, reset values and the
// elaboration-time sine table generator.
package sdm_pkg;

   typedef enum logic {
      SDM_ORDER1 = 1'b0,
      SDM_ORDER2 = 1'b1
   } sdm_order_e;

   localparam logic RST_OUT   = 1'b0;
   localparam logic RST_TRIG  = 1'b0;
   localparam logic RST_READY = 1'b1;

   // Offset-binary zero of a dw-bit sample.
   function automatic int midscale(int dw);
      return 1 << (dw - 1);
   endfunction

   // Entry k of a full-wave table: round(A + A*sin(2*pi*k/n)),
   // A = M - 0.5. Folded to the first quadrant so the
   // zero crossings are exact and round up to M.
   function automatic int sine_val(int k, int aw, int dw);
      real pi;
      real x;
      real term;
      real s;
      real a;
      int  n;
      int  r;
      pi = 3.141592653589793;
      n  = 1 << aw;
      r  = k % (n / 2);
      if (r > n / 4) r = n / 2 - r;
      x    = 2.0 * pi * real'(r) / real'(n);
      term = x;
      s    = x;
      for (int i = 1; i < 9; i++) begin
         term = -term * x * x / real'((2 * i) * (2 * i + 1));
         s    = s + term;
      end
      if ((k % n) >= n / 2) s = -s;
      a = real'(midscale(dw)) - 0.5;
      r = $rtoi(a + a * s + 0.5);
      if (r < 0) r = 0;
      if (r > (1 << dw) - 1) r = (1 << dw) - 1;
      return r;
   endfunction

endpackage

// File: rtl/sine_rom.sv
// sine_rom: registered synchronous-read sine table,
// contents built at elaboration from sdm_pkg.
import sdm_pkg::*;

module sine_rom #(
   parameter int LUT_AW = 6,
   parameter int DW     = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [LUT_AW-1:0] i_addr,
   output logic [DW-1:0]     o_data
);

   localparam int N = 1 << LUT_AW;
   localparam logic [DW-1:0] MID = DW'(midscale(DW));

   logic [DW-1:0] rom [N];
   logic [DW-1:0] data_q;

   for (genvar g = 0; g < N; g++) begin : g_rom
      assign rom[g] = DW'(sine_val(g, LUT_AW, DW));
   end

   // Read register; rests at midscale so a fresh block is silent.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_q <= MID;
      end else if (i_en) begin
         data_q <= rom[i_addr];
      end
   end

   assign o_data = data_q;

endmodule

// File: rtl/sine_sdm_gen.sv
// sine_sdm_gen: DDS sine source with amplitude scaling
// feeding a 1st/2nd order delta-sigma modulator.
import sdm_pkg::*;

module sine_sdm_gen #(
   parameter int ACC_WIDTH = 24,
   parameter int LUT_AW    = 6,
   parameter int DW        = 8,
   parameter int AMP_WIDTH = 8,
   parameter int ORDER     = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic [ACC_WIDTH-1:0] i_ftw,
   input  logic                 i_ftw_valid,
   output logic                 o_ftw_ready,
   input  logic [AMP_WIDTH-1:0] i_amp,
   output logic                 o_out,
   output logic                 o_trig,
   output logic [DW-1:0]        o_sample
);

   localparam int IW = DW + 4;
   localparam int EW = IW + 2;
   localparam int PW = DW + AMP_WIDTH + 2;
   localparam sdm_order_e ORD =
      (ORDER == 2) ? SDM_ORDER2 : SDM_ORDER1;
   localparam logic [DW-1:0] MID = DW'(midscale(DW));
   localparam logic signed [EW-1:0] MID_E = EW'(MID);
   localparam logic signed [IW-1:0] IMAX =
      {1'b0, {(IW-1){1'b1}}};
   localparam logic signed [IW-1:0] IMIN =
      {1'b1, {(IW-1){1'b0}}};

   if (ORDER != 1 && ORDER != 2) begin : g_bad_order
      $error("sine_sdm_gen: ORDER must be 1 or 2");
   end

   logic [ACC_WIDTH-1:0] phase_q, act_q, pend_q;
   logic                 rdy_q;
   logic                 wrap_q, w1_q, w2_q, trig_q;
   logic [DW-1:0]        smp_q, smp_d, rom_q;
   logic                 out_q, out_d;
   logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d;

   logic [ACC_WIDTH:0]   sum;
   logic                 copy;
   logic signed [DW:0]   dev;
   logic signed [PW-1:0] dev_x, amp_x, prod;
   logic signed [EW-1:0] xs_e, fb_e, a1, a2;

   function automatic logic signed [IW-1:0] sat(
      input logic signed [EW-1:0] v
   );
      if (v > EW'(IMAX)) return IMAX;
      if (v < EW'(IMIN)) return IMIN;
      return IW'(v);
   endfunction

   assign sum  = {1'b0, phase_q} + {1'b0, act_q};
   assign copy = ~rdy_q & (~i_en | sum[ACC_WIDTH]);

   sine_rom #(
      .LUT_AW (LUT_AW),
      .DW     (DW)
   ) u_rom (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_en),
      .i_addr  (phase_q[ACC_WIDTH-1 -: LUT_AW]),
      .o_data  (rom_q)
   );

   // Amplitude scaler and modulator next-state.
   always_comb begin
      dev   = $signed({1'b0, rom_q}) - $signed({1'b0, MID});
      dev_x = PW'(dev);
      amp_x = PW'({1'b0, i_amp});
      prod  = dev_x * amp_x;
      smp_d = MID + DW'(prod >>> AMP_WIDTH);
      xs_e  = EW'(smp_q) - MID_E;
      fb_e  = out_q ? MID_E : -MID_E;
      a1    = EW'(i1_q) + xs_e - fb_e;
      i1_d  = sat(a1);
      a2    = EW'(i2_q) + EW'(i1_d) - fb_e;
      i2_d  = sat(a2);
      out_d = (ORD == SDM_ORDER2) ? ~i2_d[IW-1] : ~i1_d[IW-1];
   end

   // Phase, scaled sample and modulator advance only when enabled.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_q <= '0;
         wrap_q  <= 1'b0;
         w1_q    <= 1'b0;
         w2_q    <= 1'b0;
         trig_q  <= RST_TRIG;
         smp_q   <= MID;
         out_q   <= RST_OUT;
         i1_q    <= '0;
         i2_q    <= '0;
      end else if (i_en) begin
         phase_q <= sum[ACC_WIDTH-1:0];
         wrap_q  <= sum[ACC_WIDTH];
         w1_q    <= wrap_q;
         w2_q    <= w1_q;
         trig_q  <= w2_q;
         smp_q   <= smp_d;
         out_q   <= out_d;
         i1_q    <= i1_d;
         i2_q    <= i2_d;
      end
   end

   // FTW handshake: one pending word, swapped in at phase wrap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rdy_q  <= RST_READY;
         pend_q <= '0;
         act_q  <= '0;
      end else if (copy) begin
         act_q  <= pend_q;
         rdy_q  <= 1'b1;
      end else if (i_ftw_valid && rdy_q) begin
         pend_q <= i_ftw;
         rdy_q  <= 1'b0;
      end
   end

   assign o_ftw_ready = rdy_q;
   assign o_out       = out_q;
   assign o_trig      = trig_q & i_en;
   assign o_sample    = smp_q;

endmodule
